iob_sync_assim_fifo: RTL

- Single-clock FIFO with independent write and read data widths; either side may be the wider one.
- Stores data in minimum-width units and tracks fill level in those units.
- Read port has 1-cycle registered latency, matching the team's RAM-style read timing.
- Sits between width-mismatched datapaths, e.g. 32-bit bus to 8-bit serialiser, or 8-bit ingest to 64-bit DMA.

---
 rtl/iob_sync_assim_fifo_pkg.sv | 31 +++
 rtl/iob_assim_fifo_ptr.sv | 32 +++
 rtl/iob_sync_assim_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/iob_sync_assim_fifo_pkg.sv
// Shared constants and elaboration helpers for the asymmetric-width FIFO.
// Unit-width/ratio derivations live here so the top and pointer agree.
package iob_sync_assim_fifo_pkg;

  localparam int DEF_W_DATA_W = 32;
  localparam int DEF_R_DATA_W = 8;
  localparam int DEF_ADDR_W   = 6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int min_w(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MIN_W     = min_w(DEF_W_DATA_W, DEF_R_DATA_W);
  localparam int MAX_W     = max_w(DEF_W_DATA_W, DEF_R_DATA_W);
  localparam int W_RATIO   = DEF_W_DATA_W / MIN_W;
  localparam int R_RATIO   = DEF_R_DATA_W / MIN_W;
  localparam int W_RATIO_L = clog2(W_RATIO);
  localparam int R_RATIO_L = clog2(R_RATIO);

endpackage

// File: rtl/iob_assim_fifo_ptr.sv
// FIFO address pointer: advances by STEP units per accepted access, wraps
// naturally at 2**ADDR_W.
module iob_assim_fifo_ptr #(
  parameter int ADDR_W = 6,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              acc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  // STEP may equal the full depth; truncation then gives the correct wrap.
  localparam logic [ADDR_W:0] STEP_W = (ADDR_W+1)'(STEP);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (acc_i) ptr_d = ptr_q + STEP_W[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/iob_sync_assim_fifo.sv
// Single-clock FIFO with independent write/read widths, stored in min-width units.
// Optional sticky error flags under `define IOB_SYNC_ASSIM_FIFO_ERR_EN.
module iob_sync_assim_fifo
  import iob_sync_assim_fifo_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] data_in,
  output logic                full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] data_out,
  output logic                empty,
`ifdef IOB_SYNC_ASSIM_FIFO_ERR_EN
  output logic                w_overflow,
  output logic                r_underflow,
`endif
  output logic [ADDR_W:0]     level
);

  localparam int UNIT_W = min_w(W_DATA_W, R_DATA_W);
  localparam int WIDE_W = max_w(W_DATA_W, R_DATA_W);
  localparam int W_RAT  = W_DATA_W / UNIT_W;
  localparam int R_RAT  = R_DATA_W / UNIT_W;
  localparam int DEPTH  = 2**ADDR_W;

  localparam logic [ADDR_W:0] W_STEP   = (ADDR_W+1)'(W_RAT);
  localparam logic [ADDR_W:0] R_STEP   = (ADDR_W+1)'(R_RAT);
  localparam logic [ADDR_W:0] FULL_THR = (ADDR_W+1)'(DEPTH - W_RAT);

  if (ADDR_W < clog2(WIDE_W / UNIT_W)) begin : g_bad_depth
    $error("ADDR_W too small for the width ratio");
  end

  logic [ADDR_W-1:0]   wptr, rptr;
  logic [ADDR_W:0]     level_q, level_d;
  logic                wacc, racc;
  logic [UNIT_W-1:0]   mem_q [DEPTH];
  logic [R_DATA_W-1:0] dout_q, rd_word;

  assign full  = (level_q > FULL_THR);
  assign empty = (level_q < R_STEP);
  assign wacc  = w_en && !full && !clr;
  assign racc  = r_en && !empty && !clr;

  iob_assim_fifo_ptr #(.ADDR_W(ADDR_W), .STEP(W_RAT)) u_wptr (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .acc_i(wacc), .ptr_o(wptr)
  );
  iob_assim_fifo_ptr #(.ADDR_W(ADDR_W), .STEP(R_RAT)) u_rptr (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .acc_i(racc), .ptr_o(rptr)
  );

  // Storage is deliberately not reset; only pointers/level define validity.
  always_ff @(posedge clk) begin
    if (wacc)
      for (int k = 0; k < W_RAT; k++)
        mem_q[wptr + ADDR_W'(k)] <= data_in[UNIT_W*k +: UNIT_W];
  end

  // Oldest unit lands in the LSBs of the read word.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < R_RAT; k++)
      rd_word[UNIT_W*k +: UNIT_W] = mem_q[rptr + ADDR_W'(k)];
  end

  always_comb begin
    level_d = level_q;
    if (wacc) level_d = level_d + W_STEP;
    if (racc) level_d = level_d - R_STEP;
    if (clr)  level_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      dout_q  <= '0;
    end else begin
      level_q <= level_d;
      if (racc) dout_q <= rd_word;
    end
  end

  assign level    = level_q;
  assign data_out = dout_q;

`ifdef IOB_SYNC_ASSIM_FIFO_ERR_EN
  logic w_ovf_q, r_unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ovf_q <= 1'b0;
      r_unf_q <= 1'b0;
    end else if (clr) begin
      w_ovf_q <= 1'b0;
      r_unf_q <= 1'b0;
    end else begin
      if (w_en && full)  w_ovf_q <= 1'b1;
      if (r_en && empty) r_unf_q <= 1'b1;
    end
  end

  assign w_overflow  = w_ovf_q;
  assign r_underflow = r_unf_q;
`endif

endmodule
